// File: rtl/dff_pkg.sv
// Shared constants and types for the elastic register pipeline and its bench.
package dff_pkg;

    localparam int DFF_WIDTH = 8;
    localparam int DFF_DEPTH = 3;

    // Width of a counter able to hold 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [DFF_WIDTH-1:0] data;
    } dff_hs_t;

endpackage

// File: rtl/dff_pipe_stage.sv
// One elastic stage: a valid bit plus data register that loads whenever it is
// empty or its downstream neighbour is taking its current beat.
module dff_pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_valid_i,
    input  logic [WIDTH-1:0] up_data_i,
    input  logic             down_ready_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // An empty stage accepts even while downstream stalls, which collapses bubbles.
    assign ready_o = !valid_q || down_ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (ready_o) begin
            valid_d = up_valid_i;
            if (up_valid_i) begin
                data_d = up_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/dff_pipe.sv
// Elastic register pipeline: DEPTH cascaded stages with valid/ready on both
// sides, synchronous flush and a live count of occupied stages.
module dff_pipe
    import dff_pkg::*;
#(
    parameter int               WIDTH     = DFF_WIDTH,
    parameter int               DEPTH     = DFF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          din,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          dout,
    output logic [occ_w(DEPTH)-1:0]   occupancy
);

    localparam int OCC_W = occ_w(DEPTH);

    logic [DEPTH:0]   ready_w;
    logic [DEPTH-1:0] valid_w;
    logic [WIDTH-1:0] data_w [DEPTH];
    logic             accept_w;
    logic [OCC_W-1:0] occ_sum;

    // The ready chain ripples combinationally from the consumer back to the producer.
    assign ready_w[DEPTH] = out_ready;
    assign in_ready       = ready_w[0] && !flush;
    assign accept_w       = in_valid && in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic             up_valid;
            logic [WIDTH-1:0] up_data;

            if (gi == 0) begin : g_head
                assign up_valid = accept_w;
                assign up_data  = din;
            end else begin : g_body
                assign up_valid = valid_w[gi-1];
                assign up_data  = data_w[gi-1];
            end

            dff_pipe_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk          (clk),
                .rst          (rst),
                .flush        (flush),
                .up_valid_i   (up_valid),
                .up_data_i    (up_data),
                .down_ready_i (ready_w[gi+1]),
                .ready_o      (ready_w[gi]),
                .valid_o      (valid_w[gi]),
                .data_o       (data_w[gi])
            );
        end
    endgenerate

    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_sum = occ_sum + OCC_W'(valid_w[i]);
        end
    end

    assign occupancy = occ_sum;
    assign out_valid = valid_w[DEPTH-1];
    assign dout      = data_w[DEPTH-1];

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe (WIDTH=8, DEPTH=3): reset, streaming, backpressure,
// bubble collapse, flush and reset-over-flush, with hand-computed expectations.
module tb_dff_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] din;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dout;
    logic [1:0]       occupancy;

    int passed = 0;
    int total  = 0;

    dff_pipe #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1. Reset with a beat presented that must never appear.
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; din = 8'h5A; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dout", dout, 8'h00);
        chk("rst_occ", occupancy, 0);
        chk("rst_in_ready", in_ready, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rst_no_5a", out_valid, 0);
        end

        // 2. Streaming 01..08 with out_ready high: first beat after the third edge, no gaps.
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = (k < 8);
            din      = 8'(k + 1);
            #1;
            chk("stream_in_ready", in_ready, 1);
            tick();
            chk("stream_out_valid", out_valid, (k >= 2) ? 1 : 0);
            if (k >= 2) chk("stream_dout", dout, k - 1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drained_valid", out_valid, 0);
        chk("stream_drained_occ", occupancy, 0);

        // 3. Backpressure: three beats fill the pipe, the fourth waits.
        out_ready = 1'b0;
        in_valid = 1'b1; din = 8'h11; tick();
        din = 8'h22; tick();
        din = 8'h33; tick();
        chk("full_occ", occupancy, 3);
        chk("full_out_valid", out_valid, 1);
        chk("full_dout", dout, 8'h11);
        din = 8'h44;
        #1;
        chk("full_in_ready", in_ready, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_dout", dout, 8'h11);
            chk("stall_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_occ", occupancy, 3);
        end
        out_ready = 1'b1;
        #1;
        chk("full_pass_in_ready", in_ready, 1);
        tick();
        chk("full_pass_occ", occupancy, 3);
        chk("drain_dout_22", dout, 8'h22);
        in_valid = 1'b0;
        #1;
        chk("full_pass_in_ready2", in_ready, 1);
        tick();
        chk("drain_dout_33", dout, 8'h33);
        chk("drain_occ_2", occupancy, 2);
        tick();
        chk("drain_dout_44", dout, 8'h44);
        chk("drain_occ_1", occupancy, 1);
        tick();
        chk("drain_empty", out_valid, 0);
        chk("drain_occ_0", occupancy, 0);

        // 4. Bubble collapse under stall: A1, gap, A2.
        out_ready = 1'b0;
        in_valid = 1'b1; din = 8'hA1;
        #1; chk("bub_in_ready0", in_ready, 1);
        tick();
        in_valid = 1'b0;
        #1; chk("bub_in_ready1", in_ready, 1);
        tick();
        in_valid = 1'b1; din = 8'hA2;
        #1; chk("bub_in_ready2", in_ready, 1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("bub_occ", occupancy, 2);
        chk("bub_dout", dout, 8'hA1);
        chk("bub_out_valid", out_valid, 1);
        chk("bub_in_ready3", in_ready, 1);
        tick();
        chk("bub_occ_hold", occupancy, 2);
        out_ready = 1'b1;
        tick();
        chk("bub_dout_a2", dout, 8'hA2);
        chk("bub_dout_a2_valid", out_valid, 1);
        tick();
        chk("bub_empty", out_valid, 0);

        // 5. Flush a full pipe while presenting AA.
        out_ready = 1'b0;
        in_valid = 1'b1; din = 8'hB1; tick();
        din = 8'hB2; tick();
        din = 8'hB3; tick();
        chk("fl_occ_before", occupancy, 3);
        flush = 1'b1; din = 8'hAA;
        #1; chk("fl_in_ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_occ", occupancy, 0);
        chk("fl_dout_held", dout, 8'hB1);
        chk("fl_in_ready_after", in_ready, 1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("fl_nothing_out", out_valid, 0);
        end

        // 6. Reset and flush together with two beats held, then resume.
        out_ready = 1'b0;
        in_valid = 1'b1; din = 8'hC1; tick();
        din = 8'hC2; tick();
        chk("rf_occ_before", occupancy, 2);
        rst = 1'b1; flush = 1'b1; din = 8'h5A;
        tick();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("rf_out_valid", out_valid, 0);
        chk("rf_dout", dout, 8'h00);
        chk("rf_occ", occupancy, 0);
        chk("rf_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = (k < 3);
            din      = 8'(8'hD1 + k);
            tick();
            chk("rf_resume_valid", out_valid, (k >= 2) ? 1 : 0);
            if (k >= 2) chk("rf_resume_dout", dout, 8'hD1 + k - 2);
        end
        in_valid = 1'b0;
        tick();
        chk("rf_resume_empty", out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
Parametrised elastic register pipeline: DEPTH cascaded WIDTH-bit register stages with a per-stage valid bit and valid/ready handshake on both sides.
It is the successor to the single-stage dff and adds:
- backpressure
- bubble collapsing
- synchronous flush
- an occupancy count

It sits between a producer and a consumer on one clock domain. It is driven and checked through the same interface/env style of bench as dff.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 3, number of register stages (>=1)
RESET_VAL, '0, value loaded into every data register on reset (WIDTH bits)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
flush  input  1  synchronous clear of all stage valids
in_valid  input  1  producer presents din
in_ready  output  1  pipeline accepts din this cycle
din  input  WIDTH  input data
out_valid  output  1  dout holds a valid beat
out_ready  input  1  consumer accepts dout this cycle
dout  output  WIDTH  output data (last stage register)
occupancy  output  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- Reset is synchronous, active-high, single clock: clk. On a rst edge:
  - all valid[i] <= 0 and all data[i] <= RESET_VAL.
  - After reset: out_valid=0, dout=RESET_VAL, occupancy=0, in_ready=1.
  - rst has priority over flush and over any handshake.
- Stage i (0 = input side, DEPTH-1 = output side) has ready[i] = !valid[i] || ready[i+1], with ready[DEPTH] = out_ready.
  - The ready chain is combinational; a combinational path out_ready -> in_ready is permitted.
- in_ready = ready[0] && !flush.
- out_valid = valid[DEPTH-1]; dout = data[DEPTH-1]. Both are registered, with no combinational path from din.
- Stage update on each clk edge, when not in rst or flush:
  - If ready[i]: valid[i] <= valid[i-1] (valid[-1] = in_valid && in_ready).
  - If ready[i] and the upstream stage is valid: data[i] <= data[i-1] (data[-1] = din).
  - Otherwise data[i] holds.
- Bubbles collapse: an empty stage accepts from upstream even while downstream stalls.
- Latency: a beat accepted at edge N appears on dout in the cycle after edge N+DEPTH-1. For DEPTH=1 this is a plain registered DFF with valid.
- Throughput: one beat per cycle when out_ready=1 continuously. No gaps, even when full (simultaneous accept/emit).
- Ordering: beats leave in acceptance order. A beat is never duplicated or dropped, except by flush or rst.
- dout and out_valid are held stable while out_valid=1 and out_ready=0.
- Flush:
  - At the edge: all valid <= 0; data registers hold their values.
  - in_ready=0 during the flush cycle, so din is dropped.
  - occupancy=0 the next cycle.
- occupancy = popcount(valid[DEPTH-1:0]), registered-equivalent. Range 0..DEPTH.
- Full: when occupancy=DEPTH and out_ready=0, in_ready=0. When full and out_ready=1, in_ready=1 and occupancy is unchanged.
- Empty: out_valid=0 and dout holds the last emitted value (or RESET_VAL). Consumers must ignore dout unless out_valid=1.

Decomposition:
- Package dff_pkg holds:
  - default WIDTH/DEPTH constants
  - function occ_w(depth) = $clog2(depth+1)
  - typedef for the handshake struct {valid, data} used by the bench transaction class
- Sub-module dff_pipe_stage: one valid+data register with ready-in/ready-out, load enable and flush/rst. dff_pipe instantiates DEPTH of them in a generate loop and computes occupancy.
- The bench interface extends dff_intf with flush, in_valid, in_ready, out_valid, out_ready, occupancy.

Test Plan:
1. Reset: rst=1 for 2 cycles with in_valid=1, din=8'h5A -> out_valid=0, dout=8'h00, occupancy=0, in_ready=1; 8'h5A never emitted.
2. Streaming: WIDTH=8, DEPTH=3, out_ready=1, din=8'h01..8'h08 on consecutive cycles -> dout=8'h01 with out_valid 3 cycles after first accept, then 8'h02..8'h08 back-to-back with no gaps.
3. Backpressure and full: out_ready=0, push 8'h11,8'h22,8'h33,8'h44 -> first three accepted, occupancy=3, in_ready=0, dout=8'h11 stable for 5 cycles; then set out_ready=1 -> 8'h11,8'h22,8'h33,8'h44 in order, none lost; full plus out_ready=1 keeps in_ready=1 and occupancy=3.
4. Bubble collapse: out_ready=0, in_valid pattern 1,0,1 (8'hA1, -, 8'hA2) -> beats settle in stages 2 and 1, occupancy=2, in_ready=1 throughout.
5. Flush: occupancy=3, flush=1 with in_valid=1, din=8'hAA -> next cycle out_valid=0, occupancy=0; 8'hAA and the flushed beats never appear.
6. Reset mid-operation: occupancy=2 with flush=1, rst=1 in the same cycle -> next cycle state identical to test 1, dout=RESET_VAL; normal streaming resumes correctly afterwards.
